aes256_cipher_core: RTL and testbench

- Iterative AES-256 encryption datapath; sits directly downstream of the combinational key-expansion block and consumes its 1920-bit round-key schedule.
- Processes one round per clock: AddRoundKey(rk0), then NR rounds of SubBytes/ShiftRows/MixColumns/AddRoundKey. The final round omits MixColumns.
- Uses valid/ready handshakes on input and output.

---
 rtl/aes_pkg.sv | 44 ++++
 rtl/aes256_cipher_core_round.sv | 38 +++
 rtl/aes256_cipher_core.sv | 120 ++++++++++++
 tb/tb_aes256_cipher_core.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: state type, S-box, xtime and round-key slicing.
package aes_pkg;

  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;

  // Slice helper operates on a schedule padded to 16 round keys so any 4-bit index is in range
  localparam int KS_MAX_W = 128 * 16;

  typedef logic [0:127] state_t;

  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[int'(b)*8 +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic state_t round_key(input logic [0:KS_MAX_W-1] ks, input logic [3:0] r);
    return ks[int'(r)*128 +: 128];
  endfunction

endpackage

// File: rtl/aes256_cipher_core_round.sv
// Combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  state_t state,
  input  state_t round_key,
  input  logic   final_round,
  output state_t next_state
);

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  state_t sb, sr, mc;

  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    for (int i = 0; i < 16; i++) sb[i*8 +: 8] = sbox(state[i*8 +: 8]);
    // byte (row r, col c) lives at index 4c+r; row r rotates left by r columns
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[(4*c+r)*8 +: 8] = sb[(4*((c+r)%4)+r)*8 +: 8];
    for (int c = 0; c < 4; c++) mc[c*32 +: 32] = mix_column(sr[c*32 +: 32]);
    next_state = (final_round ? sr : mc) ^ round_key;
  end

endmodule

// File: rtl/aes256_cipher_core.sv
// Iterative AES encryption core, one round per clock, valid/ready on both sides.
// Optional AES_KEY_LATCH_EN: latch the key schedule on accept so upstream may change it.
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// ROUND | applying round rnd (1..NR) to the state register
// DONE  | ciphertext presented, waiting for out_ready
module aes256_cipher_core
  import aes_pkg::*;
#(
  parameter int NR = NR_AES256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [0:127]          plaintext,
  input  logic [0:128*(NR+1)-1] keyschedule,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [0:127]          ciphertext,
  output logic                  busy
);

  localparam int KS_W = 128 * (NR + 1);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  state_t       st_q, st_d;
  state_t       rnd_out;
  logic         accept;
  logic         final_round;
  logic [0:KS_W-1]     ks_src;
  logic [0:KS_MAX_W-1] ks_ext;

  assign accept = (fsm_q == IDLE) && in_valid;

`ifdef AES_KEY_LATCH_EN
  logic [0:KS_W-1] key_buf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      key_buf <= '0;
    else if (accept) key_buf <= keyschedule;
  end

  assign ks_src = key_buf;
`else
  assign ks_src = keyschedule;
`endif

  always_comb begin
    ks_ext = '0;
    ks_ext[0:KS_W-1] = ks_src;
  end

  assign final_round = (rnd_q == 4'(NR));

  aes_round u_round (
    .state      (st_q),
    .round_key  (round_key(ks_ext, rnd_q)),
    .final_round(final_round),
    .next_state (rnd_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
      rnd_q <= '0;
      st_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      rnd_q <= rnd_d;
      st_q  <= st_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    rnd_d = rnd_q;
    st_d  = st_q;
    case (fsm_q)
      IDLE: begin
        if (accept) begin
          st_d  = plaintext ^ keyschedule[0:127];
          rnd_d = 4'd1;
          fsm_d = ROUND;
        end
      end
      ROUND: begin
        if (rnd_q == 4'd0 || rnd_q > 4'(NR)) begin
          fsm_d = IDLE;
          rnd_d = '0;
        end else begin
          st_d = rnd_out;
          if (final_round) begin
            fsm_d = DONE;
            rnd_d = '0;
          end else begin
            rnd_d = rnd_q + 4'd1;
          end
        end
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: begin
        fsm_d = IDLE;
        rnd_d = '0;
      end
    endcase
  end

  assign in_ready   = (fsm_q == IDLE);
  assign out_valid  = (fsm_q == DONE);
  assign busy       = (fsm_q == ROUND) || (fsm_q == DONE);
  assign ciphertext = out_valid ? st_q : '0;

endmodule

// File: tb/tb_aes256_cipher_core.sv
// Directed bench for aes256_cipher_core: known-answer vectors plus handshake corner cases.
module tb_aes256_cipher_core;

  localparam int NR   = 14;
  localparam int KS_W = 128 * (NR + 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [0:127]    plaintext;
  logic [0:KS_W-1] keyschedule;
  logic            out_valid;
  logic            out_ready;
  logic [0:127]    ciphertext;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;

  aes256_cipher_core #(.NR(NR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .keyschedule(keyschedule),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Independent S-box built from the GF(2^8) inverse and affine map, for key expansion only
  logic [7:0] sb_tab [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] calc_sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb_tab[w[31:24]], sb_tab[w[23:16]], sb_tab[w[15:8]], sb_tab[w[7:0]]};
  endfunction

  function automatic logic [0:KS_W-1] expand(input logic [0:255] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [0:KS_W-1] ks;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[i*32 +: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int i = 0; i < 60; i++) ks[i*32 +: 32] = w[i];
    return ks;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_ne(input string name, input logic [127:0] act, input logic [127:0] bad);
    n_cmp++;
    if (act === bad) begin
      n_bad++;
      $display("FAIL %s: got %h which should differ from %h", name, act, bad);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, performs the accept edge, then scrambles plaintext
  task automatic launch(input logic [0:KS_W-1] ks, input logic [0:127] pt);
    int n = 0;
    keyschedule = ks;
    plaintext   = pt;
    in_valid    = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) chk("accept_timeout", 128'(in_ready), 128'd1);
    tick();
    in_valid  = 1'b0;
    plaintext = '1;
  endtask

  // Counts edges after the accept edge until out_valid rises
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 128'(out_valid), 128'd1);
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    tick();
    chk({name, "_in_ready_after"}, 128'(in_ready), 128'd1);
    chk({name, "_out_valid_after"}, 128'(out_valid), 128'd0);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [0:255] key;
    logic [0:127] pt;
    logic [0:127] ct;
  } vec_t;

  vec_t vecs [3];

  localparam logic [0:255] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [0:127] PT_C3  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [0:255] KEY_SP = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [0:127] PT_SP1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [0:127] CT_SP1 = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
  localparam logic [0:127] PT_SP2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [0:127] CT_SP2 = 128'h591ccb10d410ed26dc5ba74a31362870;

  initial begin
    logic [0:KS_W-1] ks_c3, ks_sp;
    logic [0:127]    held_ct;
    logic [0:127]    got [2];
    int              acc_edge [2];
    int              lat, acc, outs;

    vecs[0] = '{key: KEY_C3, pt: PT_C3,  ct: CT_C3};
    vecs[1] = '{key: KEY_SP, pt: PT_SP1, ct: CT_SP1};
    vecs[2] = '{key: KEY_SP, pt: PT_SP2, ct: CT_SP2};

    for (int i = 0; i < 256; i++) sb_tab[i] = calc_sbox(8'(i));
    ks_c3 = expand(KEY_C3);
    ks_sp = expand(KEY_SP);

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    plaintext   = '0;
    keyschedule = '0;
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_ciphertext", ciphertext, 128'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Known-answer vectors with latency check
    for (int i = 0; i < 3; i++) begin
      launch(expand(vecs[i].key), vecs[i].pt);
      chk($sformatf("vec%0d_busy", i), 128'(busy), 128'd1);
      chk($sformatf("vec%0d_in_ready_low", i), 128'(in_ready), 128'd0);
      wait_out(lat);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(NR));
      chk($sformatf("vec%0d_ct", i), ciphertext, vecs[i].ct);
      handshake($sformatf("vec%0d", i));
    end

    // Backpressure: DONE holds for 20 cycles
    launch(ks_c3, PT_C3);
    wait_out(lat);
    held_ct = ciphertext;
    chk("bp_ct", held_ct, CT_C3);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("bp_ct_stable%0d", k), ciphertext, held_ct);
      chk($sformatf("bp_out_valid%0d", k), 128'(out_valid), 128'd1);
      chk($sformatf("bp_in_ready%0d", k), 128'(in_ready), 128'd0);
    end
    handshake("bp");

    // Back-to-back: in_valid and out_ready held high, second block uses the other key
    keyschedule = ks_c3;
    plaintext   = PT_C3;
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    acc  = 0;
    outs = 0;
    acc_edge[0] = 0;
    acc_edge[1] = 0;
    got[0] = '0;
    got[1] = '0;
    for (int e = 0; e < 80 && (acc < 2 || outs < 2); e++) begin
      logic acc_now, out_now;
      logic [0:127] ct_now;
      acc_now = in_valid && in_ready;
      out_now = out_valid && out_ready;
      ct_now  = ciphertext;
      tick();
      if (acc_now) begin
        acc_edge[acc] = e;
        acc++;
        if (acc == 1) plaintext = PT_SP1;
        else in_valid = 1'b0;
      end
      if (out_now) begin
        got[outs] = ct_now;
        outs++;
        keyschedule = ks_sp;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_accepts", 128'(acc), 128'd2);
    chk("b2b_outputs", 128'(outs), 128'd2);
    chk("b2b_spacing", 128'(acc_edge[1] - acc_edge[0]), 128'(NR + 2));
    chk("b2b_ct0", got[0], CT_C3);
    chk("b2b_ct1", got[1], CT_SP1);
    tick();

    // Reset during round 7 abandons the block
    launch(ks_c3, PT_C3);
    repeat (6) tick();
    chk("mid_busy_before", 128'(busy), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", 128'(out_valid), 128'd0);
    chk("mid_in_ready", 128'(in_ready), 128'd1);
    chk("mid_busy", 128'(busy), 128'd0);
    chk("mid_ciphertext", ciphertext, 128'd0);
    tick();
    rst_n = 1'b1;
    tick();
    launch(ks_c3, PT_C3);
    wait_out(lat);
    chk("mid_after_latency", 128'(lat), 128'(NR));
    chk("mid_after_ct", ciphertext, CT_C3);
    handshake("mid_after");

    // Key schedule cleared the cycle after accept
    launch(ks_c3, PT_C3);
    keyschedule = '0;
    wait_out(lat);
`ifdef AES_KEY_LATCH_EN
    chk("keychg_ct", ciphertext, CT_C3);
`else
    chk_ne("keychg_ct", ciphertext, CT_C3);
`endif
    handshake("keychg");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
